// File: rtl/adder_tree_acc.sv
// Pipelined streaming adder tree with valid/ready backpressure and optional multi-beat accumulation.
// Define ADDER_TREE_ACC_EN to enable accumulation across beats closed by i_last.
module adder_tree_acc #(
  parameter int DATAWIDTH           = 8,
  parameter int NUM_INPUTS          = 16,
  parameter int NUM_PIPELINE_STAGES = 1,
  parameter int SIGNED              = 0,
  parameter int ACC_BITS            = 8,
  localparam int LEVELS             = $clog2(NUM_INPUTS),
  localparam int TREE_W             = DATAWIDTH + LEVELS,
  localparam int OUT_W              = TREE_W + ACC_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_valid,
  output logic                                 i_ready,
  input  logic                                 i_last,
  input  logic [NUM_INPUTS-1:0][DATAWIDTH-1:0] in_data,
  output logic                                 o_valid,
  input  logic                                 o_ready,
  output logic [OUT_W-1:0]                     o_sum
);

  // Number of nodes present at tree level k (level 0 is the raw operand set).
  function automatic int lvl_cnt(input int k);
    int n;
    n = NUM_INPUTS;
    for (int j = 0; j < k; j++) n = (n + 1) / 2;
    return n;
  endfunction

  // Operands are widened to the full tree width once; partial sums can never overflow it.
  function automatic logic signed [TREE_W-1:0] ext_in(input logic [DATAWIDTH-1:0] x);
    if (SIGNED != 0) return TREE_W'($signed(x));
    return TREE_W'(x);
  endfunction

  function automatic logic signed [OUT_W-1:0] ext_out(input logic signed [TREE_W-1:0] x);
    if (SIGNED != 0) return OUT_W'(x);
    return OUT_W'($unsigned(x));
  endfunction

  logic en;
  assign en      = !o_valid || o_ready;
  assign i_ready = en;

  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int N = lvl_cnt(k);
    logic signed [TREE_W-1:0] d [N];
    logic signed [TREE_W-1:0] q [N];
    logic                     v_d, l_d, v_q, l_q;

    if (k == 0) begin : g_in
      for (genvar i = 0; i < N; i++) begin : g_op
        assign d[i] = ext_in(in_data[i]);
      end
      assign v_d = i_valid;
      assign l_d = i_last;
    end else begin : g_add
      localparam int M = lvl_cnt(k - 1);
      for (genvar i = 0; i < N; i++) begin : g_node
        if (2 * i + 1 < M) begin : g_pair
          assign d[i] = g_lvl[k-1].q[2*i] + g_lvl[k-1].q[2*i+1];
        end else begin : g_pass
          assign d[i] = g_lvl[k-1].q[2*i];
        end
      end
      assign v_d = g_lvl[k-1].v_q;
      assign l_d = g_lvl[k-1].l_q;
    end

    // slot k boundary: register or wire depending on NUM_PIPELINE_STAGES
    if (k < NUM_PIPELINE_STAGES) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
        end else if (en) begin
          v_q <= v_d;
        end
      end

      always_ff @(posedge clk) begin
        if (en) begin
          l_q <= l_d;
          for (int i = 0; i < N; i++) q[i] <= d[i];
        end
      end
    end else begin : g_wire
      assign q   = d;
      assign v_q = v_d;
      assign l_q = l_d;
    end
  end

  logic                    tree_vld;
  logic signed [OUT_W-1:0] tree_ext;
  assign tree_vld = g_lvl[LEVELS].v_q;
  assign tree_ext = ext_out(g_lvl[LEVELS].q[0]);

`ifdef ADDER_TREE_ACC_EN
  logic                    tree_last;
  logic signed [OUT_W-1:0] acc;
  assign tree_last = g_lvl[LEVELS].l_q;

  // accumulator / output boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      acc     <= '0;
    end else if (en) begin
      if (tree_vld && tree_last) begin
        o_sum   <= acc + tree_ext;
        o_valid <= 1'b1;
        acc     <= '0;
      end else begin
        if (tree_vld) acc <= acc + tree_ext;
        o_valid <= 1'b0;
      end
    end
  end
`else
  // Without accumulation the last tag carries no meaning.
  logic unused_last;
  assign unused_last = g_lvl[LEVELS].l_q;

  // output boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
    end else if (en) begin
      if (tree_vld) begin
        o_sum   <= tree_ext;
        o_valid <= 1'b1;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: doc/adder_tree_acc.md
# adder_tree_acc

Parametrised, pipelined, streaming reduction tree with valid/ready backpressure, signed/unsigned operand mode and a multi-beat accumulator. Each accepted beat carries NUM_INPUTS operands. These are reduced by a binary adder tree with a configurable number of register slots, then added into a running total that closes on a beat tagged `i_last`. It is the next-generation reduction primitive for the dot-product and pooling datapaths, replacing the fixed single-beat tree.

## Interface
- DATAWIDTH, 8, operand width in bits.
- NUM_INPUTS, 16, operands per beat (≥2; need not be a power of two).
- NUM_PIPELINE_STAGES, 1, number of enabled tree register slots (0..LEVELS+1).
- SIGNED, 0, 1 = operands are two's complement; 0 = unsigned.
- ACC_BITS, 8, extra accumulator headroom bits.
- Derived: LEVELS = $clog2(NUM_INPUTS); TREE_W = DATAWIDTH+LEVELS; OUT_W = TREE_W+ACC_BITS.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input beat valid.
- i_ready  out  1  block can accept a beat this cycle.
- i_last  in  1  beat closes the current accumulation.
- in_data  in  [NUM_INPUTS-1:0][DATAWIDTH-1:0]  operands.
- o_valid  out  1  o_sum holds a completed result.
- o_ready  in  1  downstream accepts result.
- o_sum  out  OUT_W  completed sum.

## Operation
- Register slots: slot 0 is after the input; slot k is after tree level k (k = 1..LEVELS). Slots 0..NUM_PIPELINE_STAGES-1 are registers; the rest are wires.
- Each slot carries data, a valid bit and a last bit.
- Tree level k adds adjacent pairs at width DATAWIDTH+k.
- An odd trailing operand passes through unpaired, extended by one bit.
- Extension is sign extension when SIGNED=1, zero extension otherwise.
- Global stall: en = !o_valid || o_ready. All slot registers, the accumulator and the output register update only when en=1. i_ready = en.
- No bubble collapsing; an invalid beat advances as a bubble.
- Accumulator stage: the partial register `acc` (OUT_W bits) and the output register are both always present. The tree result is extended to OUT_W.
  - Valid beat with last=0: acc ← acc + tree.
  - Valid beat with last=1: o_sum ← acc + tree, o_valid ← 1, acc ← 0.
- Otherwise, when en=1, o_valid clears if o_ready was high (result consumed).
- Arithmetic: accumulation wraps modulo 2^OUT_W; there is no overflow flag.
- Reset: all slot valids, o_valid, acc and o_sum are cleared to 0. i_ready = 1 during and after reset.
- Reset mid-accumulation discards the partial sum and any in-flight beats.

## Timing
- Latency from accepted last beat to o_valid is NUM_PIPELINE_STAGES+1 cycles without stall. NUM_PIPELINE_STAGES=0 gives 1 cycle.
- Throughput is one beat per cycle while o_ready=1.
- With o_valid=1 and o_ready=0: i_ready=0 in the same cycle (combinational from o_valid/o_ready). The pipeline freezes and o_sum, o_valid hold stable.
- o_valid && o_ready together with a new last beat arriving at the accumulator in the same cycle: the new result loads and o_valid stays 1, with no bubble.
- A beat is accepted only on i_valid && i_ready. in_data and i_last are ignored otherwise.

## Configuration
- `ADDER_TREE_ACC_EN` defined: multi-beat accumulation as described.
- Undefined:
  - i_last is ignored and every valid beat is treated as last.
  - acc is removed (constant 0).
  - o_sum = tree result extended to OUT_W.
  - Latency, handshake and reset behaviour are unchanged.

## Test plan
- Unsigned, NUM_INPUTS=16, DATAWIDTH=8, all operands 255, i_last=1, o_ready=1 → o_sum=4080 exactly NUM_PIPELINE_STAGES+1 cycles after acceptance.
- SIGNED=1, NUM_INPUTS=5, operands {-128, 127, -1, 3, -7}, i_last=1 → o_sum=-6 sign-correct at OUT_W bits; exercises the odd-operand pass-through.
- ACC_EN, three beats of all-1 operands (NUM_INPUTS=16) with i_last on the third → single o_valid pulse with o_sum=48; a following one-beat group of all-2 operands → o_sum=32 (acc cleared).
- Hold o_ready=0 with o_valid=1 for 5 cycles while i_valid=1 → i_ready=0, o_sum stable. Release → streaming resumes with no lost or duplicated beats (scoreboard compare).
- Assert rst mid-group after two non-last beats, then send one beat of all-1s with i_last → o_sum=16; all outputs are 0 during reset.
- Sweep NUM_PIPELINE_STAGES 0..LEVELS+1 under random valid/ready → results match a reference model, with latency = stages+1 when unstalled.
